ram_shift_ctrl: RTL and testbench

Sequencing controller for the RAM-based shift register (simple dual-port RAM, registered read, 1-cycle read latency, read-old-data on same-address collision). Owns the circular write and read pointers, the run-time programmable tap length, fill tracking and output-valid alignment. Also runs a RAM zero-clear sweep. Sits between the sample-producing datapath and the RAM instance, and drives all RAM control inputs.

---
 rtl/ram_shift_ctrl.sv | 123 ++++++++++++
 tb/tb_ram_shift_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ram_shift_ctrl.sv
// Sequencer for a RAM-based shift register: circular pointers, programmable tap length,
// fill/valid tracking and a full-depth zero sweep. RAM addresses are combinational from registers.
module ram_shift_ctrl #(
   parameter int SIZE        = 512,
   parameter int ADDR        = 9,
   parameter int DEFAULT_LEN = 16
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            shift_en,
   input  logic            cfg_load,
   input  logic [ADDR:0]   cfg_len,
   input  logic            clr_req,
   output logic            ram_clk_en,
   output logic [ADDR-1:0] ram_wr_addr,
   output logic [ADDR-1:0] ram_rd_addr,
   output logic            ram_rd_en,
   output logic            ram_zero,
   output logic            out_valid,
   output logic            busy,
   output logic            cfg_err,
   output logic [ADDR:0]   tap_len_q
);

   localparam int LW = ADDR + 1;
   localparam logic [ADDR:0]   LEN_MAX  = LW'(SIZE);
   localparam logic [ADDR:0]   LEN_ONE  = LW'(1);
   localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);
   localparam logic [ADDR-1:0] CLR_LAST = ADDR'(SIZE - 1);

   typedef enum logic [1:0] {S_FILL, S_RUN, S_CLEAR} state_t;

   state_t          state_q, state_d;
   logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR-1:0] clr_cnt_q, clr_cnt_d;
   logic [ADDR:0]   fill_q, fill_d;
   logic [ADDR:0]   tap_len_d;
   logic            out_valid_q, out_valid_d;
   logic            cfg_err_q, cfg_err_d;
   logic            in_clear, do_shift, cfg_ok, cfg_take;

   assign in_clear = (state_q == S_CLEAR);
   // An accepted clear request outranks a shift in the same cycle.
   assign do_shift = !in_clear && shift_en && !clr_req;
   assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
   assign cfg_take = cfg_load && (in_clear || !clr_req);

   // tap_len_q == SIZE wraps to rd == wr; the RAM's read-old-data returns the oldest sample.
   assign ram_wr_addr = wr_ptr_q;
   assign ram_rd_addr = wr_ptr_q - tap_len_q[ADDR-1:0];
   assign ram_clk_en  = in_clear || do_shift;
   assign ram_rd_en   = do_shift;
   assign ram_zero    = in_clear;
   assign busy        = in_clear;
   assign out_valid   = out_valid_q;
   assign cfg_err     = cfg_err_q;

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      clr_cnt_d   = clr_cnt_q;
      fill_d      = fill_q;
      tap_len_d   = tap_len_q;
      out_valid_d = out_valid_q;
      cfg_err_d   = 1'b0;

      if (in_clear) begin
         wr_ptr_d  = wr_ptr_q + PTR_ONE;
         clr_cnt_d = clr_cnt_q + PTR_ONE;
      end else if (clr_req) begin
         state_d   = S_CLEAR;
         clr_cnt_d = '0;
      end else if (do_shift) begin
         wr_ptr_d    = wr_ptr_q + PTR_ONE;
         out_valid_d = (fill_q == tap_len_q);
         if (fill_q != tap_len_q) begin
            fill_d = fill_q + LEN_ONE;
         end
         state_d = (fill_d == tap_len_q) ? S_RUN : S_FILL;
      end

      if (cfg_take) begin
         if (cfg_ok) begin
            tap_len_d   = cfg_len;
            fill_d      = '0;
            out_valid_d = 1'b0;
            if (!in_clear) begin
               state_d = S_FILL;
            end
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      // End of sweep: the whole delay line now reads zero, so it is full and valid.
      if (in_clear && (clr_cnt_q == CLR_LAST)) begin
         state_d     = S_RUN;
         fill_d      = tap_len_d;
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= S_FILL;
         wr_ptr_q    <= '0;
         clr_cnt_q   <= '0;
         fill_q      <= '0;
         tap_len_q   <= LW'(DEFAULT_LEN);
         out_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         clr_cnt_q   <= clr_cnt_d;
         fill_q      <= fill_d;
         tap_len_q   <= tap_len_d;
         out_valid_q <= out_valid_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_ram_shift_ctrl.sv
// Bench for ram_shift_ctrl with a behavioural RAM; a delay-line queue model feeds a scoreboard.
module tb_ram_shift_ctrl;
   localparam int SIZE = 512;
   localparam int ADDR = 9;
   localparam int DEF  = 16;

   logic            CLK = 1'b0;
   logic            reset = 1'b0;
   logic            shift_en = 1'b0, cfg_load = 1'b0, clr_req = 1'b0;
   logic [ADDR:0]   cfg_len = '0;
   logic            ram_clk_en, ram_rd_en, ram_zero, out_valid, busy, cfg_err;
   logic [ADDR-1:0] ram_wr_addr, ram_rd_addr;
   logic [ADDR:0]   tap_len_q;
   logic [15:0]     din = '0;
   logic [15:0]     shiftout;
   logic [15:0]     mem [SIZE];

   always #5 CLK = ~CLK;

   ram_shift_ctrl #(.SIZE(SIZE), .ADDR(ADDR), .DEFAULT_LEN(DEF)) dut (
      .CLK(CLK), .reset(reset), .shift_en(shift_en), .cfg_load(cfg_load), .cfg_len(cfg_len),
      .clr_req(clr_req), .ram_clk_en(ram_clk_en), .ram_wr_addr(ram_wr_addr),
      .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_zero(ram_zero),
      .out_valid(out_valid), .busy(busy), .cfg_err(cfg_err), .tap_len_q(tap_len_q)
   );

   // Simple dual-port RAM, registered read, old data on same-address collision.
   always @(posedge CLK) begin
      if (ram_clk_en) begin
         if (ram_rd_en) shiftout <= mem[ram_rd_addr];
         mem[ram_wr_addr] <= ram_zero ? 16'h0 : din;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   typedef struct {
      bit              vld;
      logic [15:0]     dat;
      logic [ADDR-1:0] wr;
      logic [ADDR-1:0] rd;
   } exp_t;
   exp_t sbq[$];

   // Reference model: delay line of written samples (newest first) plus counters.
   logic [15:0] line[$];
   int  wr_m = 0, since_m = 0, tap_m = DEF, clr_left = 0;
   bit  ov_m = 0, err_m = 0;

   // Monitor: after each shift edge the RAM output and out_valid are compared.
   bit              pend = 0;
   logic [ADDR-1:0] wr_c, rd_c;
   exp_t            me;
   always @(negedge CLK) begin
      if (pend) begin
         if (sbq.size() == 0) chk("sb_underflow", 1, 0);
         else begin
            me = sbq.pop_front();
            chk("sb_valid", out_valid, me.vld);
            if (me.vld) chk("sb_data", shiftout, me.dat);
            chk("sb_wr_addr", wr_c, me.wr);
            chk("sb_rd_addr", rd_c, me.rd);
         end
      end
      pend = ram_rd_en && !reset;
      wr_c = ram_wr_addr;
      rd_c = ram_rd_addr;
   end

   task automatic step(input bit sh, input bit cl, input bit ld, input int len);
      bit was_busy, eff_sh, ld_ok;
      exp_t e;
      logic [15:0] d;
      @(posedge CLK); #1;
      chk("busy", busy, clr_left > 0);
      chk("ram_zero", ram_zero, clr_left > 0);
      chk("out_valid", out_valid, ov_m);
      chk("cfg_err", cfg_err, err_m);
      chk("tap_len", tap_len_q, tap_m);
      was_busy = (clr_left > 0);
      if (was_busy) chk("clr_addr", ram_wr_addr, wr_m);

      d = 16'($urandom);
      shift_en = sh; clr_req = cl; cfg_load = ld; cfg_len = len[ADDR:0]; din = d;

      err_m  = 0;
      eff_sh = sh && !was_busy && !cl;
      ld_ok  = 0;
      if (ld && (was_busy || !cl)) begin
         if (len >= 1 && len <= SIZE) ld_ok = 1;
         else err_m = 1;
      end
      if (eff_sh) begin
         e.wr  = ADDR'(wr_m);
         e.rd  = ADDR'((wr_m - tap_m + SIZE) % SIZE);
         e.vld = (since_m >= tap_m) && !ld_ok;
         e.dat = (e.vld && line.size() >= tap_m) ? line[tap_m-1] : 16'h0;
         sbq.push_back(e);
         line.push_front(d);
         if (line.size() > SIZE) void'(line.pop_back());
         wr_m = (wr_m + 1) % SIZE;
         since_m++;
         ov_m = e.vld;
      end
      if (ld_ok) begin
         tap_m = len; since_m = 0; ov_m = 0;
      end
      if (!was_busy && cl) clr_left = SIZE;
      if (was_busy) begin
         wr_m = (wr_m + 1) % SIZE;
         clr_left--;
         if (clr_left == 0) begin
            line.delete();
            repeat (SIZE) line.push_back(16'h0);
            since_m = tap_m;
            ov_m = 1;
         end
      end
      #1;
      chk("ram_clk_en", ram_clk_en, was_busy || eff_sh);
      chk("ram_rd_en", ram_rd_en, eff_sh);
   endtask

   task automatic do_reset(input bit pre_idle);
      if (pre_idle) step(0, 0, 0, 0);
      @(posedge CLK); #1;
      shift_en = 0; clr_req = 0; cfg_load = 0;
      #2 reset = 1;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_ram_zero", ram_zero, 0);
      chk("rst_tap_len", tap_len_q, DEF);
      chk("rst_wr_addr", ram_wr_addr, 0);
      chk("rst_rd_addr", ram_rd_addr, SIZE - DEF);
      chk("rst_clk_en", ram_clk_en, 0);
      @(posedge CLK); #1;
      reset = 0;
      wr_m = 0; since_m = 0; tap_m = DEF; clr_left = 0; ov_m = 0; err_m = 0;
      line.delete();
   endtask

   initial begin
      do_reset(0);
      // Default tap, back-to-back shifts.
      repeat (40) step(1, 0, 0, 0);
      // Maximum tap, pointer wraps twice.
      step(0, 0, 1, SIZE);
      repeat (1100) step(1, 0, 0, 0);
      // Short tap with one shift every third cycle.
      step(0, 0, 1, 3);
      for (int i = 0; i < 36; i++) step(i % 3 == 0, 0, 0, 0);
      // Retune during RUN with a coincident shift, then illegal lengths.
      step(0, 0, 1, 5);
      repeat (10) step(1, 0, 0, 0);
      step(1, 0, 1, 8);
      repeat (10) step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 1, SIZE + 1);
      step(0, 0, 0, 0);
      // Zero sweep starting at pointer 100; shifts and repeated clears are ignored.
      while (wr_m != 100) step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (SIZE) step(1'($urandom % 2), 1'($urandom % 2), 0, 0);
      repeat (20) step(1, 0, 0, 0);
      // Randomized shifts and retunes.
      for (int i = 0; i < 400; i++) begin
         int len;
         len = ($urandom % 4 == 0) ? int'($urandom_range(0, SIZE + 8)) : int'($urandom_range(1, 12));
         step($urandom % 3 != 0, 0, $urandom % 20 == 0, len);
      end
      // Reset mid-RUN, then mid-CLEAR; FILL must resume normally.
      do_reset(1);
      repeat (30) step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (100) step(1, 0, 0, 0);
      do_reset(1);
      repeat (30) step(1'($urandom % 2), 0, 0, 0);
      repeat (3) step(0, 0, 0, 0);
      chk("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
